decode_wb_seq: RTL and testbench
================================

# decode_wb_seq

Decode and write-back stage of the sequential Y86-64 core. Sits directly downstream of `fetch_seq`. It takes the fetched `in_code`/`in_fun`/`ra`/`rb` fields and produces the source and destination register IDs and the operand values `val_a` and `val_b` for execute. It holds the 15-entry architectural register file, commits `val_e`/`val_m` at the clock edge, and tracks the sticky processor status (AOK/HLT/ADR/INS) plus a retired-instruction counter.

## Interface
Parameters:
- `STACK_TOP`, default 64'd1024: reset value of %rsp (reg 4) when `RSP_INIT_EN` is defined.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_code`  in  4  icode from fetch.
- `in_fun`  in  4  ifun from fetch (unused except for documentation; cmov is gated by `cnd`).
- `ra`, `rb`  in  4 each  register specifiers from fetch; 15 means none.
- `flag_halt`, `bad_mem`, `in_error`  in  1 each  fetch status flags.
- `cnd`  in  1  condition result from execute.
- `val_e`  in  64  ALU result from execute.
- `val_m`  in  64  data-memory read value from memory.
- `wb_valid`  in  1  commit strobe: the current instruction retires at this edge.
- `src_a`, `src_b`, `dst_e`, `dst_m`  out  4 each  decoded register IDs (combinational).
- `val_a`, `val_b`  out  64 each  register read data (combinational).
- `stat`  out  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS (registered).
- `retired`  out  64  count of committed instructions (registered).

## Operation
Register ID decode is combinational. %rsp is 4. The "none" value is F.
- `src_a`:
  - rA for icodes 2, 4, 6, A.
  - %rsp for icodes 9, B.
  - F otherwise.
- `src_b`:
  - rB for icodes 4, 5, 6.
  - %rsp for icodes 8, 9, A, B.
  - F otherwise.
- `dst_e`:
  - rB for icode 2 when `cnd`=1, and for icodes 3 and 6.
  - %rsp for icodes 8, 9, A, B.
  - F otherwise, including icode 2 with `cnd`=0.
- `dst_m`:
  - rA for icodes 5 and B.
  - F otherwise.

Register reads:
- `val_a` = regs[`src_a`] and `val_b` = regs[`src_b`].
- ID F reads as 0.
- Reads are asynchronous and never bypass a same-cycle write.

Status state machine, 4 states, sticky. An edge is a "commit" when `wb_valid`=1 and `stat`==AOK.
- AOK → ADR when `bad_mem`=1 at a commit.
- AOK → INS when `in_error`=1 and `bad_mem`=0 at a commit.
- AOK → HLT when `flag_halt`=1 and neither fault flag is set at a commit.
- HLT, ADR and INS are terminal and are left only by `reset`.

Write-back at a commit with `bad_mem`=0 and `in_error`=0:
- regs[`dst_e`] ← `val_e` if `dst_e`≠F.
- regs[`dst_m`] ← `val_m` if `dst_m`≠F.
- If `dst_e`==`dst_m`, the `val_m` write wins. Example: popq %rsp leaves %rsp = popped value.
- `retired` increments by 1. A halt instruction counts.

Suppressed cycles:
- A faulting commit writes no register and does not increment `retired`.
- When `stat`≠AOK, `wb_valid` is ignored: no writes, no count.
- When `wb_valid`=0, nothing changes.

## Timing
- Decode outputs are valid combinationally, in the same cycle as the fetch outputs. Zero-cycle latency.
- Register writes, `stat` and `retired` update at the posedge where the commit occurs. Values are visible to reads in the following cycle.
- `reset` takes priority over everything at the edge where it is sampled high:
  - all registers 0 (except %rsp, see Configuration);
  - `stat` = 1 (AOK);
  - `retired` = 0.
- Decode outputs after reset: `val_a`/`val_b` read the reset register values. ID outputs track the inputs.
- Reset asserted in the same cycle as a commit: the reset wins and the write is discarded.
- `retired` wraps from 2^64−1 to 0 with no flag.

## Configuration
- `RSP_INIT_EN` defined: %rsp resets to `STACK_TOP`; all other registers reset to 0.
- `RSP_INIT_EN` undefined: %rsp resets to 0 like every other register, and `STACK_TOP` is ignored.

## Test plan
- Reset, then commit irmovq with `in_code`=3, rb=2, `val_e`=0x55 → next cycle `src_b`=2 gives `val_b`=0x55; `retired`=1.
- OPq with `in_code`=6, ra=1, rb=2, regs[1]=7, regs[2]=5 → `src_a`=1, `val_a`=7, `val_b`=5, `dst_e`=2. After a commit with `val_e`=12, regs[2]=12.
- Conditional move:
  - `in_code`=2, `cnd`=0 → `dst_e`=F; after commit regs[rb] unchanged.
  - `cnd`=1 → regs[rb] = `val_e`.
- popq %rsp: `in_code`=B, ra=4, `val_e`=0x108, `val_m`=0xABC → %rsp=0xABC after commit.
- Commit with `bad_mem`=1 → `stat`=3, no register change, `retired` unchanged. Further `wb_valid` pulses are ignored until `reset`, which restores `stat`=1.
- Halt commit → `stat`=2, `retired`+1. With `RSP_INIT_EN`, `STACK_TOP`=0x200: after reset `in_code`=9 gives `val_a`=`val_b`=0x200. Without the macro, both read 0.

Source files
------------

// File: rtl/decode_wb_seq.sv
// decode_wb_seq: decode and write-back stage of the sequential Y86-64 core.
// Decodes register IDs from the fetched icode, reads the 15-entry register
// file, commits val_e/val_m on a retiring edge, and tracks the sticky status
// and the retired-instruction count.
// Optional feature macro: RSP_INIT_EN (when defined, %rsp resets to STACK_TOP).

module decode_wb_seq #(
    parameter logic [63:0] STACK_TOP = 64'd1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  in_code,
    input  logic [3:0]  in_fun,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic        flag_halt,
    input  logic        bad_mem,
    input  logic        in_error,
    input  logic        cnd,
    input  logic [63:0] val_e,
    input  logic [63:0] val_m,
    input  logic        wb_valid,
    output logic [3:0]  src_a,
    output logic [3:0]  src_b,
    output logic [3:0]  dst_e,
    output logic [3:0]  dst_m,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    output logic [2:0]  stat,
    output logic [63:0] retired
);

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

`ifdef RSP_INIT_EN
    localparam logic [63:0] RSP_RESET = STACK_TOP;
`else
    localparam logic [63:0] RSP_RESET = 64'd0;
    logic [63:0] unusedStackTop;
    assign unusedStackTop = STACK_TOP;
`endif

    // ifun only distinguishes variants inside execute; cmov is qualified by cnd
    logic unusedFun;
    assign unusedFun = ^in_fun;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } statE;

    statE        stat_q, stat_d;
    logic [63:0] regs_q [15];
    logic [63:0] regs_d [15];
    logic [63:0] retired_q, retired_d;
    logic        commit;
    logic        writeEn;

    // Register ID decode from the icode; unused ports default to "none"
    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (in_code)
            4'h2: begin
                src_a = ra;
                if (cnd) dst_e = rb;
            end
            4'h3: dst_e = rb;
            4'h4: begin
                src_a = ra;
                src_b = rb;
            end
            4'h5: begin
                src_b = rb;
                dst_m = ra;
            end
            4'h6: begin
                src_a = ra;
                src_b = rb;
                dst_e = rb;
            end
            4'h8: begin
                src_b = REG_RSP;
                dst_e = REG_RSP;
            end
            4'h9, 4'hB: begin
                src_a = REG_RSP;
                src_b = REG_RSP;
                dst_e = REG_RSP;
                if (in_code == 4'hB) dst_m = ra;
            end
            4'hA: begin
                src_a = ra;
                src_b = REG_RSP;
                dst_e = REG_RSP;
            end
            default: ;
        endcase
    end

    // Asynchronous register reads; the "none" ID reads as zero
    always_comb begin
        val_a = 64'd0;
        val_b = 64'd0;
        if (src_a != REG_NONE) val_a = regs_q[src_a];
        if (src_b != REG_NONE) val_b = regs_q[src_b];
    end

    // Status state register
    always_ff @(posedge clock) begin
        if (reset) stat_q <= STAT_AOK;
        else       stat_q <= stat_d;
    end

    // Status next state: only a commit from AOK can move it, faults take priority over halt
    always_comb begin
        stat_d = stat_q;
        if (stat_q == STAT_AOK && wb_valid) begin
            if (bad_mem)        stat_d = STAT_ADR;
            else if (in_error)  stat_d = STAT_INS;
            else if (flag_halt) stat_d = STAT_HLT;
        end
    end

    // Status outputs: commit qualification and the write enable for retiring state
    always_comb begin
        commit  = wb_valid && (stat_q == STAT_AOK);
        writeEn = commit && !bad_mem && !in_error;
        stat    = stat_q;
    end

    // Register file and retire counter next state; the val_m write is applied last so it wins
    always_comb begin
        regs_d    = regs_q;
        retired_d = retired_q;
        if (writeEn) begin
            if (dst_e != REG_NONE) regs_d[dst_e] = val_e;
            if (dst_m != REG_NONE) regs_d[dst_m] = val_m;
            retired_d = retired_q + 64'd1;
        end
    end

    // Register file and retire counter state
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= (i == 4) ? RSP_RESET : 64'd0;
            retired_q <= 64'd0;
        end else begin
            regs_q    <= regs_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_decode_wb_seq.sv
// tb_decode_wb_seq: scoreboard bench for decode_wb_seq.
// A driver issues directed and random instructions, pushing the expected
// decode/read/status values from an architectural model; a monitor pops and
// compares each cycle's outputs mid-cycle.

module tb_decode_wb_seq;

    localparam logic [63:0] TB_STACK_TOP = 64'h200;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  in_code, in_fun, ra, rb;
    logic        flag_halt, bad_mem, in_error, cnd, wb_valid;
    logic [63:0] val_e, val_m;
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] val_a, val_b, retired;
    logic [2:0]  stat;

    decode_wb_seq #(.STACK_TOP(TB_STACK_TOP)) dut (
        .clock(clock), .reset(reset), .in_code(in_code), .in_fun(in_fun),
        .ra(ra), .rb(rb), .flag_halt(flag_halt), .bad_mem(bad_mem),
        .in_error(in_error), .cnd(cnd), .val_e(val_e), .val_m(val_m),
        .wb_valid(wb_valid), .src_a(src_a), .src_b(src_b), .dst_e(dst_e),
        .dst_m(dst_m), .val_a(val_a), .val_b(val_b), .stat(stat),
        .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  srcA, srcB, dstE, dstM;
        logic [63:0] valA, valB, retired;
        logic [2:0]  stat;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;

    // Architectural model state
    logic [63:0] mRegs [15];
    logic [2:0]  mStat;
    logic [63:0] mRetired;

    function automatic logic [3:0] specSrcA(input logic [3:0] c, input logic [3:0] a);
        if (c inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (c inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] specSrcB(input logic [3:0] c, input logic [3:0] b);
        if (c inside {4'h4, 4'h5, 4'h6}) return b;
        if (c inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] specDstE(input logic [3:0] c, input logic [3:0] b, input logic k);
        if ((c == 4'h2 && k) || c inside {4'h3, 4'h6}) return b;
        if (c inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] specDstM(input logic [3:0] c, input logic [3:0] a);
        if (c inside {4'h5, 4'hB}) return a;
        return 4'hF;
    endfunction

    function automatic logic [63:0] readModel(input logic [3:0] id);
        if (id == 4'hF) return 64'd0;
        return mRegs[id];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 15; i++) mRegs[i] = 64'd0;
`ifdef RSP_INIT_EN
        mRegs[4] = TB_STACK_TOP;
`endif
        mStat    = 3'd1;
        mRetired = 64'd0;
    endtask

    // Drive one cycle of inputs, push the expected outputs, then advance the model past the edge
    task automatic applyStimulus(input logic [3:0] code, input logic [3:0] a, input logic [3:0] b,
                                 input logic halt, input logic badm, input logic inerr,
                                 input logic k, input logic [63:0] ve, input logic [63:0] vm,
                                 input logic wbv, input logic rst);
        expT e;
        logic [3:0] de, dm;
        @(posedge clock);
        #2;
        in_code = code; in_fun = 4'($urandom); ra = a; rb = b;
        flag_halt = halt; bad_mem = badm; in_error = inerr; cnd = k;
        val_e = ve; val_m = vm; wb_valid = wbv; reset = rst;
        e.srcA = specSrcA(code, a);
        e.srcB = specSrcB(code, b);
        e.dstE = specDstE(code, b, k);
        e.dstM = specDstM(code, a);
        e.valA = readModel(e.srcA);
        e.valB = readModel(e.srcB);
        e.stat = mStat;
        e.retired = mRetired;
        expQ.push_back(e);
        de = e.dstE;
        dm = e.dstM;
        if (rst) begin
            modelReset();
        end else if (wbv && mStat == 3'd1) begin
            if (badm) mStat = 3'd3;
            else if (inerr) mStat = 3'd4;
            else begin
                if (de != 4'hF) mRegs[de] = ve;
                if (dm != 4'hF) mRegs[dm] = vm;
                mRetired = mRetired + 64'd1;
                if (halt) mStat = 3'd2;
            end
        end
    endtask

    task automatic op(input logic [3:0] code, input logic [3:0] a, input logic [3:0] b,
                      input logic [63:0] ve, input logic [63:0] vm, input logic wbv);
        applyStimulus(code, a, b, 1'b0, 1'b0, 1'b0, 1'b1, ve, vm, wbv, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Monitor: every mid-cycle the DUT outputs are compared with the oldest expectation
    initial begin
        expT e;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("src_a", 64'(src_a), 64'(e.srcA));
                checkOutput("src_b", 64'(src_b), 64'(e.srcB));
                checkOutput("dst_e", 64'(dst_e), 64'(e.dstE));
                checkOutput("dst_m", 64'(dst_m), 64'(e.dstM));
                checkOutput("val_a", val_a, e.valA);
                checkOutput("val_b", val_b, e.valB);
                checkOutput("stat", 64'(stat), 64'(e.stat));
                checkOutput("retired", retired, e.retired);
            end
        end
    end

    initial begin
        reset = 1'b1; in_code = 4'h1; in_fun = 4'h0; ra = 4'hF; rb = 4'hF;
        flag_halt = 1'b0; bad_mem = 1'b0; in_error = 1'b0; cnd = 1'b0;
        val_e = 64'd0; val_m = 64'd0; wb_valid = 1'b0;
        modelReset();

        // reset state, then irmovq 0x55 -> %rdx and read it back
        op(4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
        op(4'h3, 4'hF, 4'h2, 64'h55, 64'd0, 1'b1);
        op(4'h5, 4'hF, 4'h2, 64'd0, 64'd0, 1'b0);
        // OPq with regs[1]=7, regs[2]=5, result 12
        op(4'h3, 4'hF, 4'h1, 64'd7, 64'd0, 1'b1);
        op(4'h3, 4'hF, 4'h2, 64'd5, 64'd0, 1'b1);
        op(4'h6, 4'h1, 4'h2, 64'd12, 64'd0, 1'b1);
        op(4'h6, 4'h1, 4'h2, 64'd0, 64'd0, 1'b0);
        // cmov not taken, then taken
        applyStimulus(4'h2, 4'h1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 64'h99, 64'd0, 1'b1, 1'b0);
        op(4'h4, 4'h1, 4'h3, 64'd0, 64'd0, 1'b0);
        applyStimulus(4'h2, 4'h1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 64'h77, 64'd0, 1'b1, 1'b0);
        op(4'h4, 4'h1, 4'h3, 64'd0, 64'd0, 1'b0);
        // popq %rsp: the memory value wins over the incremented stack pointer
        op(4'hB, 4'h4, 4'hF, 64'h108, 64'hABC, 1'b1);
        op(4'h9, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
        // address fault is sticky; later commits are ignored until reset
        applyStimulus(4'h3, 4'hF, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1234, 64'd0, 1'b1, 1'b0);
        op(4'h3, 4'hF, 4'h5, 64'h4321, 64'd0, 1'b1);
        op(4'h3, 4'hF, 4'h5, 64'h4321, 64'd0, 1'b1);
        applyStimulus(4'h3, 4'hF, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1, 64'd0, 1'b1, 1'b1);
        op(4'h9, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
        // instruction fault, then reset racing a commit
        applyStimulus(4'h3, 4'hF, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 64'h66, 64'd0, 1'b1, 1'b0);
        op(4'h4, 4'h6, 4'h6, 64'd0, 64'd0, 1'b0);
        applyStimulus(4'h3, 4'hF, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 64'h66, 64'd0, 1'b1, 1'b1);
        // halt commit counts and stops the machine
        op(4'h3, 4'hF, 4'h7, 64'h70, 64'd0, 1'b1);
        applyStimulus(4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 1'b1, 1'b0);
        op(4'h3, 4'hF, 4'h7, 64'h71, 64'd0, 1'b1);
        applyStimulus(4'h1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
        op(4'h9, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);

        // randomized traffic with rare faults, halts and resets
        for (int n = 0; n < 600; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 29) == 0), ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 59) == 0), 1'($urandom),
                          {$urandom, $urandom}, {$urandom, $urandom},
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0));
        end

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clock);
        #1;
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
